// File: rtl/network_pkg.sv
// Shared network-wide constants and types for the rate-coding input stage.
package network_pkg;

  localparam int INPUT_SIZE       = 4;
  localparam int PIXEL_WIDTH      = 8;
  localparam int TICK_DIV_DEFAULT = 25;
  localparam int STEP_W_DEFAULT   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  typedef logic [PIXEL_WIDTH-1:0] pixel_frame_t [INPUT_SIZE];

endpackage

// File: rtl/pixel_frame_buffer.sv
// Stream loader: collects one frame of pixels into a shadow buffer and holds it
// until the scheduler swaps it into the active register.
module pixel_frame_buffer #(
  parameter int INPUT_SIZE  = network_pkg::INPUT_SIZE,
  parameter int PIXEL_WIDTH = network_pkg::PIXEL_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pix_valid,
  input  logic [PIXEL_WIDTH-1:0]            pix_data,
  input  logic                              pix_last,
  output logic                              pix_ready,
  input  logic                              swap,
  input  logic                              clear,
  output logic [INPUT_SIZE*PIXEL_WIDTH-1:0] shadow,
  output logic                              shadow_full,
  output logic                              frame_err
);
  import network_pkg::*;

  localparam int IW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(INPUT_SIZE - 1);

  logic [IW-1:0] idx;
  logic          accept;
  logic          frame_end;

  // Handshake: a pixel transfers in any cycle where pix_valid && pix_ready.
  // pix_ready depends only on shadow occupancy, never on pix_valid.
  assign pix_ready = !shadow_full;
  assign accept    = pix_valid && pix_ready && !clear;
  assign frame_end = pix_last || (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow      <= '0;
      idx         <= '0;
      shadow_full <= 1'b0;
      frame_err   <= 1'b0;
    end else if (clear) begin
      idx         <= '0;
      shadow_full <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (swap) shadow_full <= 1'b0;
      if (accept) begin
        // An early pix_last zero-fills the tail so stale pixels never reach the encoder.
        for (int j = 0; j < INPUT_SIZE; j++) begin
          if (IW'(j) == idx)
            shadow[j*PIXEL_WIDTH +: PIXEL_WIDTH] <= pix_data;
          else if (pix_last && (IW'(j) > idx))
            shadow[j*PIXEL_WIDTH +: PIXEL_WIDTH] <= '0;
        end
        if (frame_end) begin
          shadow_full <= 1'b1;
          idx         <= '0;
          if (pix_last != (idx == IDX_LAST)) frame_err <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spike_frame_scheduler.sv
// Frame sequencer: swaps a loaded frame into the active register, then emits
// frame_start, a programmable number of step_tick pulses and frame_done.
module spike_frame_scheduler #(
  parameter int INPUT_SIZE  = network_pkg::INPUT_SIZE,
  parameter int PIXEL_WIDTH = network_pkg::PIXEL_WIDTH,
  parameter int TICK_DIV    = network_pkg::TICK_DIV_DEFAULT,
  parameter int STEP_W      = network_pkg::STEP_W_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pix_valid,
  input  logic [PIXEL_WIDTH-1:0]            pix_data,
  input  logic                              pix_last,
  output logic                              pix_ready,
  input  logic [STEP_W-1:0]                 cfg_steps,
  input  logic                              abort,
  output logic [INPUT_SIZE*PIXEL_WIDTH-1:0] pixel_value,
  output logic                              frame_start,
  output logic                              step_tick,
  output logic                              frame_done,
  output logic                              busy,
  output logic                              frame_err,
  output logic [1:0]                        state_dbg
);
  import network_pkg::*;

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_DIV - 2);

  sched_state_t                       state;
  logic [TW-1:0]                      tick_cnt;
  logic [STEP_W-1:0]                  step_cnt;
  logic [STEP_W-1:0]                  steps_q;
  logic [INPUT_SIZE*PIXEL_WIDTH-1:0]  shadow;
  logic                               shadow_full;
  logic                               swap;

  assign swap      = (state == IDLE) && shadow_full && !abort;
  assign state_dbg = state;

  pixel_frame_buffer #(
    .INPUT_SIZE (INPUT_SIZE),
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .swap       (swap),
    .clear      (abort),
    .shadow     (shadow),
    .shadow_full(shadow_full),
    .frame_err  (frame_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pixel_value <= '0;
      tick_cnt    <= '0;
      step_cnt    <= '0;
      steps_q     <= '0;
      frame_start <= 1'b0;
      step_tick   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else if (abort) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      step_cnt    <= '0;
      frame_start <= 1'b0;
      step_tick   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      step_tick   <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (shadow_full) begin
            pixel_value <= shadow;
            frame_start <= 1'b1;
            busy        <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          steps_q  <= (cfg_steps == '0) ? STEP_W'(1) : cfg_steps;
          tick_cnt <= '0;
          step_cnt <= '0;
          state    <= RUN;
        end
        RUN: begin
          // step_tick is registered, so it is raised one count early to land on TICK_LAST.
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            step_cnt <= step_cnt + 1'b1;
            if (step_cnt == steps_q - 1'b1) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end
          end else begin
            tick_cnt  <= tick_cnt + 1'b1;
            step_tick <= (tick_cnt == TICK_PRE);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_frame_scheduler.sv
// Self-checking bench for spike_frame_scheduler: frame-level reference model
// feeding an expected queue, with an independent output monitor.
module tb_spike_frame_scheduler;

  localparam int IS = 4;
  localparam int PW = 8;
  localparam int TD = 4;
  localparam int SW = 8;
  localparam int FW = IS * PW;
  localparam int QW = 33 + FW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pix_valid = 1'b0;
  logic [PW-1:0] pix_data = '0;
  logic          pix_last = 1'b0;
  logic          pix_ready;
  logic [SW-1:0] cfg_steps = '0;
  logic          abort = 1'b0;
  logic [FW-1:0] pixel_value;
  logic          frame_start;
  logic          step_tick;
  logic          frame_done;
  logic          busy;
  logic          frame_err;
  logic [1:0]    state_dbg;

  spike_frame_scheduler #(
    .INPUT_SIZE (IS),
    .PIXEL_WIDTH(PW),
    .TICK_DIV   (TD),
    .STEP_W     (SW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .cfg_steps  (cfg_steps),
    .abort      (abort),
    .pixel_value(pixel_value),
    .frame_start(frame_start),
    .step_tick  (step_tick),
    .frame_done (frame_done),
    .busy       (busy),
    .frame_err  (frame_err),
    .state_dbg  (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // reference model: frames as the stream defines them
  logic [QW-1:0] exp_q[$];
  logic [PW-1:0] mbuf [IS];
  int            mn = 0;
  logic          merr = 1'b0;

  task automatic model_accept(input logic [PW-1:0] d, input logic last);
    logic [FW-1:0] f;
    mbuf[mn] = d;
    mn++;
    if (last || mn == IS) begin
      for (int i = 0; i < IS; i++) f[i*PW +: PW] = (i < mn) ? mbuf[i] : '0;
      if (!(last && mn == IS)) merr = 1'b1;
      exp_q.push_back({32'(cyc), merr, f});
      mn = 0;
    end
  endtask

  task automatic model_flush();
    mn = 0;
    merr = 1'b0;
    exp_q.delete();
  endtask

  // monitor
  logic          in_frame = 1'b0;
  logic [FW-1:0] cur_frame = '0;
  logic [QW-1:0] mon_e;
  int            start_cyc = 0;
  int            steps = 0;
  int            ticks = 0;
  int            last_done = 0;
  int            frames_done = 0;
  int            acc_cyc;
  int            exp_start;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (in_frame) begin
        check("pixel_value_stable", pixel_value, cur_frame);
        check("busy_in_frame", busy, 1);
      end
      if (frame_start) begin
        check("start_not_in_frame", in_frame, 0);
        check("start_has_pending_frame", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          cur_frame = mon_e[FW-1:0];
          check("pixel_value", pixel_value, mon_e[FW-1:0]);
          check("frame_err", frame_err, mon_e[FW]);
          acc_cyc = int'(mon_e[QW-1:FW+1]);
          exp_start = (acc_cyc > last_done) ? acc_cyc + 2 : last_done + 2;
          check("start_cycle", cyc, exp_start);
        end
        steps = (cfg_steps == 0) ? 1 : int'(cfg_steps);
        start_cyc = cyc;
        ticks = 0;
        in_frame = 1'b1;
      end
      if (step_tick) begin
        check("tick_in_frame", in_frame, 1);
        check("tick_within_steps", ticks < steps, 1);
        check("tick_cycle", cyc, start_cyc + (ticks + 1) * TD);
        ticks++;
      end
      if (frame_done) begin
        check("done_in_frame", in_frame, 1);
        check("ticks_per_frame", ticks, steps);
        check("done_cycle", cyc, start_cyc + steps * TD + 1);
        in_frame = 1'b0;
        last_done = cyc;
        frames_done++;
      end
      if (abort) in_frame = 1'b0;
    end
  end

  // driver tasks (entered and left at posedge + 1)
  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pix(input logic [PW-1:0] d, input logic last);
    int budget = 0;
    bit done = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_last  = last;
    while (!done) begin
      @(negedge clk);
      if (pix_ready) begin
        done = 1;
        model_accept(d, last);
      end else begin
        budget++;
        if (budget > 500) begin
          check("pix_accept_budget", 0, 1);
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic send_rand_frame(input int gap_max);
    bit ovf;
    int len;
    ovf = ($urandom_range(0, 3) == 0);
    len = ovf ? IS : int'($urandom_range(1, IS));
    for (int i = 0; i < len; i++) begin
      send_pix(PW'($urandom_range(0, 255)), !ovf && (i == len - 1));
      idle_cycles(int'($urandom_range(0, gap_max)));
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || in_frame) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_within_budget", n < 2000, 1);
    idle_cycles(2);
  endtask

  task automatic wait_ticks(input int k);
    int n = 0;
    while (!(in_frame && ticks >= k) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_ticks_budget", n < 1000, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] held;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    check("reset_pixel_value", pixel_value, 0);
    check("reset_outputs", {frame_start, step_tick, frame_done, busy, frame_err}, 0);
    check("reset_pix_ready", pix_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(2);

    // 1: basic frame
    cfg_steps = 8'd3;
    send_pix(8'd32, 1'b0);
    send_pix(8'd64, 1'b0);
    send_pix(8'd128, 1'b0);
    send_pix(8'd255, 1'b1);
    @(negedge clk);
    check("t1_pix_ready_full", pix_ready, 0);
    @(posedge clk);
    #1;
    wait_idle();
    check("t1_frames_done", frames_done, 1);
    check("t1_ticks", ticks, 3);

    // 2: double buffer
    send_pix(8'd1, 1'b0);
    send_pix(8'd2, 1'b0);
    send_pix(8'd3, 1'b0);
    send_pix(8'd4, 1'b1);
    wait_ticks(0);
    send_pix(8'd10, 1'b0);
    send_pix(8'd120, 1'b0);
    send_pix(8'd200, 1'b0);
    send_pix(8'd250, 1'b1);
    @(negedge clk);
    check("t2_pix_ready_held", pix_ready, 0);
    check("t2_a_still_running", in_frame, 1);
    @(posedge clk);
    #1;
    wait_idle();
    check("t2_frames_done", frames_done, 3);

    // 3: short frame, then over-long stream
    send_pix(8'd5, 1'b0);
    send_pix(8'd6, 1'b0);
    send_pix(8'd7, 1'b1);
    wait_idle();
    for (int i = 1; i <= 5; i++) send_pix(PW'(i), 1'b0);
    send_pix(8'd11, 1'b0);
    send_pix(8'd12, 1'b1);
    wait_idle();
    check("t3_frames_done", frames_done, 6);

    // 4: cfg_steps 0, and a mid-RUN change
    cfg_steps = 8'd0;
    send_rand_frame(1);
    wait_idle();
    check("t4_cfg0_ticks", ticks, 1);
    cfg_steps = 8'd3;
    send_rand_frame(0);
    wait_ticks(1);
    cfg_steps = 8'd5;
    send_rand_frame(0);
    wait_idle();
    check("t4_next_frame_ticks", ticks, 5);

    // 5: abort during the second tick period with a half-loaded shadow
    cfg_steps = 8'd3;
    send_pix(8'd21, 1'b0);
    send_pix(8'd22, 1'b0);
    send_pix(8'd23, 1'b0);
    send_pix(8'd24, 1'b1);
    held = {8'd24, 8'd23, 8'd22, 8'd21};
    wait_ticks(1);
    send_pix(8'd77, 1'b0);
    send_pix(8'd78, 1'b0);
    pix_valid = 1'b1;
    pix_data  = 8'd99;
    pix_last  = 1'b1;
    abort     = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    pix_valid = 1'b0;
    pix_last = 1'b0;
    model_flush();
    last_done = 0;
    @(negedge clk);
    check("t5_pix_ready", pix_ready, 1);
    check("t5_frame_err_cleared", frame_err, 0);
    check("t5_busy", busy, 0);
    check("t5_pixel_value_kept", pixel_value, held);
    @(posedge clk);
    #1;
    idle_cycles(3 * TD);
    send_pix(8'd41, 1'b0);
    send_pix(8'd42, 1'b0);
    send_pix(8'd43, 1'b0);
    send_pix(8'd44, 1'b1);
    wait_idle();
    check("t5_post_abort_ticks", ticks, 3);

    // 6: reset mid-RUN and mid-load
    send_pix(8'd51, 1'b0);
    send_pix(8'd52, 1'b1);
    wait_ticks(1);
    send_pix(8'd61, 1'b0);
    send_pix(8'd62, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_reset_pixel_value", pixel_value, 0);
    check("t6_reset_outputs", {frame_start, step_tick, frame_done, busy, frame_err}, 0);
    check("t6_reset_pix_ready", pix_ready, 1);
    model_flush();
    last_done = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(5 * TD);
    send_rand_frame(1);
    wait_idle();

    // randomized traffic
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 1) == 1) cfg_steps = SW'($urandom_range(0, 4));
      send_rand_frame(2);
      idle_cycles(int'($urandom_range(0, 6)));
    end
    wait_idle();
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
